// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_memread;
    logic              mem_memwrite;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_readdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_address, mem_writedata,
        output mem_memread, mem_memwrite
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_readdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_address, mem_writedata,
        input  mem_memread, mem_memwrite
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with burst limit in front of the
// single-port data memory; returns registered read data.
module dmem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CONE = CW'(1);

    logic              last;
    logic [CW-1:0]     burst_cnt;
    logic              g0;
    logic              g1;
    logic              pick;
    logic              gid;
    logic              gwe;
    logic [ADDR_W-1:0] gaddr;
    logic [DATA_W-1:0] gwdata;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // Mid-burst the owner keeps the memory; fresh or exhausted bursts flip.
    always_comb begin
        g0   = 1'b0;
        g1   = 1'b0;
        pick = ~last;
        if (burst_cnt != '0 && burst_cnt < CMAX) begin
            pick = last;
        end
        if (!reset) begin
            if (bus.req0 && bus.req1) begin
                g0 = ~pick;
                g1 = pick;
            end else begin
                g0 = bus.req0;
                g1 = bus.req1;
            end
        end
    end

    always_comb begin
        gid    = 1'b0;
        gwe    = 1'b0;
        gaddr  = '0;
        gwdata = '0;
        if (g0) begin
            gwe    = bus.we0;
            gaddr  = bus.addr0;
            gwdata = bus.wdata0;
        end else if (g1) begin
            gid    = 1'b1;
            gwe    = bus.we1;
            gaddr  = bus.addr1;
            gwdata = bus.wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= 1'b1;
            burst_cnt <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= g0 & ~bus.we0;
            rvalid1_q <= g1 & ~bus.we1;
            if (g0 & ~bus.we0) begin
                rdata0_q <= bus.mem_readdata;
            end
            if (g1 & ~bus.we1) begin
                rdata1_q <= bus.mem_readdata;
            end
            if (g0 | g1) begin
                if (gid == last) begin
                    if (burst_cnt < CMAX) begin
                        burst_cnt <= burst_cnt + CONE;
                    end
                end else begin
                    last      <= gid;
                    burst_cnt <= CONE;
                end
            end
        end
    end

    assign bus.gnt0          = g0;
    assign bus.gnt1          = g1;
    assign bus.mem_address   = gaddr;
    assign bus.mem_writedata = gwdata;
    assign bus.mem_memwrite  = (g0 | g1) & gwe;
    assign bus.mem_memread   = (g0 | g1) & ~gwe;

    // A response already in flight when reset rises is discarded.
    assign bus.rvalid0 = rvalid0_q & ~reset;
    assign bus.rvalid1 = rvalid1_q & ~reset;
    assign bus.rdata0  = reset ? '0 : rdata0_q;
    assign bus.rdata1  = reset ? '0 : rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a rule-level reference model.
// Instance a uses MAX_BURST=4, instance b MAX_BURST=1 on the same requests.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();
    dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus_b ();

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(1)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    assign bus_b.req0         = bus.req0;
    assign bus_b.we0          = bus.we0;
    assign bus_b.addr0        = bus.addr0;
    assign bus_b.wdata0       = bus.wdata0;
    assign bus_b.req1         = bus.req1;
    assign bus_b.we1          = bus.we1;
    assign bus_b.addr1        = bus.addr1;
    assign bus_b.wdata1       = bus.wdata1;
    assign bus_b.mem_readdata = '0;

    function automatic logic [31:0] seed(int i);
        if (i == 5) return 32'hDEADBEEF;
        return 32'h1000_0000 + i * 7919;
    endfunction

    // Memory the DUT talks to
    logic [31:0] emem [1024];
    bit          loaded = 1'b0;
    assign bus.mem_readdata = emem[bus.mem_address];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) emem[i] <= seed(i);
            loaded <= 1'b1;
        end else if (bus.mem_memwrite) begin
            emem[bus.mem_address] <= bus.mem_writedata;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [1024];
    int          m_last [2];
    int          m_cnt [2];
    int          maxb [2];
    bit          pend [2];
    logic [31:0] hold [2];
    int          last_ga = -1;
    int          ha[$];
    int          hb[$];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int pick(int i, bit r0, bit r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (m_cnt[i] > 0 && m_cnt[i] < maxb[i]) return m_last[i];
        return 1 - m_last[i];
    endfunction

    task automatic upd(int i, int g);
        if (g < 0) return;
        if (g == m_last[i]) begin
            if (m_cnt[i] < maxb[i]) m_cnt[i]++;
        end else begin
            m_last[i] = g;
            m_cnt[i]  = 1;
        end
    endtask

    task automatic step();
        int          ga;
        int          gb;
        bit          gwe;
        logic [9:0]  gad;
        logic [31:0] gwd;
        logic [43:0] e;
        @(negedge clk);
        ga = -1;
        gb = -1;
        if (!reset) begin
            ga = pick(0, bus.req0, bus.req1);
            gb = pick(1, bus.req0, bus.req1);
        end
        chk("gnt0", bus.gnt0, ga == 0);
        chk("gnt1", bus.gnt1, ga == 1);
        chk("b_gnt0", bus_b.gnt0, gb == 0);
        chk("b_gnt1", bus_b.gnt1, gb == 1);
        gwe = (ga == 0) ? bus.we0 : bus.we1;
        gad = (ga == 0) ? bus.addr0 : bus.addr1;
        gwd = (ga == 0) ? bus.wdata0 : bus.wdata1;
        e = '0;
        if (ga >= 0) e = {!gwe, gwe, gad, gwd};
        chk("mem", {bus.mem_memread, bus.mem_memwrite,
                    bus.mem_address, bus.mem_writedata}, e);
        chk("rsp0", {bus.rvalid0, bus.rdata0},
            reset ? 33'd0 : {pend[0], hold[0]});
        chk("rsp1", {bus.rvalid1, bus.rdata1},
            reset ? 33'd0 : {pend[1], hold[1]});
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_last[i] = 1;
                m_cnt[i]  = 0;
                pend[i]   = 1'b0;
                hold[i]   = '0;
            end
        end else begin
            pend[0] = (ga == 0) && !gwe;
            pend[1] = (ga == 1) && !gwe;
            if (ga >= 0 && !gwe) hold[ga] = ref_mem[gad];
            if (ga >= 0 && gwe) ref_mem[gad] = gwd;
            upd(0, ga);
            upd(1, gb);
        end
        last_ga = ga;
        ha.push_back(ga);
        hb.push_back(gb);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit r0, bit w0, int a0, logic [31:0] d0,
                         bit r1, bit w1, int a1, logic [31:0] d1);
        bus.req0   = r0;
        bus.we0    = w0;
        bus.addr0  = 10'(a0);
        bus.wdata0 = d0;
        bus.req1   = r1;
        bus.we1    = w1;
        bus.addr1  = 10'(a1);
        bus.wdata1 = d1;
    endtask

    function automatic int raddr();
        int a;
        a = int'($urandom_range(0, 8));
        return (a == 8) ? 1023 : a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = seed(i);
        maxb[0] = 4;
        maxb[1] = 1;
        for (int i = 0; i < 2; i++) begin
            m_last[i] = 1;
            m_cnt[i]  = 0;
            pend[i]   = 1'b0;
            hold[i]   = '0;
        end
        drive(1, 0, 5, 0, 1, 0, 7, 0);
        @(posedge clk);
        #1;
        repeat (3) step();

        // Single read of preloaded word
        reset = 1'b0;
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Tie after reset, burst limit and strict alternation
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1, 0, 5, 0, 1, 0, 7, 0);
        ha.delete();
        hb.delete();
        repeat (10) step();
        for (int k = 0; k < 10; k++) begin
            chk("burst_seq", 64'(ha[k]), ((k % 8) < 4) ? 0 : 1);
            chk("alt_seq", 64'(hb[k]), 64'(k % 2));
        end
        drive(0, 0, 0, 0, 1, 0, 9, 0);
        repeat (4) step();

        // Write then read at the top address
        drive(0, 0, 0, 0, 1, 1, 1023, 32'h12345678);
        step();
        drive(0, 0, 0, 0, 1, 0, 1023, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("turnaround", ref_mem[1023], 32'h12345678);

        // Reset arriving right after a read grant
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        drive(1, 0, 3, 0, 1, 0, 4, 0);
        ha.delete();
        step();
        chk("post_rst_tie", 64'(ha[0]), 0);

        // Random traffic honouring the hold-until-grant rule
        for (int c = 0; c < 600; c++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 99) == 0) reset = 1'b1;
            if (!bus.req0 || last_ga == 0) begin
                bus.req0   = ($urandom_range(0, 3) != 0);
                bus.we0    = $urandom_range(0, 1) == 1;
                bus.addr0  = 10'(raddr());
                bus.wdata0 = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req0 = 1'b0;
            end
            if (!bus.req1 || last_ga == 1) begin
                bus.req1   = ($urandom_range(0, 3) != 0);
                bus.we1    = $urandom_range(0, 1) == 1;
                bus.addr1  = 10'(raddr());
                bus.wdata1 = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req1 = 1'b0;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port round-robin arbiter and sequencer placed in front of the single-port data memory (1024 x 32, address/writedata/memread/memwrite/readdata interface). Requester 0 is the CPU load/store path. Requester 1 is the CNN weight/feature-map loader. The block grants one access per cycle, drives the memory control strobes, and returns registered read data to the requester that owns it. A configurable burst limit bounds how long one requester can hold the memory while the other waits.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, data word width
MAX_BURST, 4, max consecutive grants to one requester while the other is requesting (>=1; 1 = strict alternation)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 access request (hold until gnt0)
we0  input  1  requester 0: 1 = write, 0 = read
addr0  input  ADDR_W  requester 0 word address
wdata0  input  DATA_W  requester 0 write data
gnt0  output  1  requester 0 access accepted this cycle
rvalid0  output  1  requester 0 read data valid
rdata0  output  DATA_W  requester 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as requester 0, for requester 1
mem_address  output  ADDR_W  to memory address
mem_writedata  output  DATA_W  to memory writedata
mem_memread  output  1  to memory memread
mem_memwrite  output  1  to memory memwrite
mem_readdata  input  DATA_W  from memory readdata (valid in the issue cycle)

Behaviour:
- Clock: one clock, clk. Reset: synchronous, active-high, named reset.
- Transfer: a transfer occurs in a cycle when reqN && gntN. gnt is combinational from req and the registered state. At most one gnt per cycle (gnt0 && gnt1 is never 1).
- Requester rule: reqN, weN, addrN and wdataN must stay stable until gntN. Dropping req before gnt is allowed and means the request is withdrawn.
- State registers:
  - last (1b): owner of the most recent transfer. Reset value 1, so requester 0 wins the first tie.
  - burst_cnt: consecutive transfers by last, width clog2(MAX_BURST+1). Reset value 0.
- Arbitration, each cycle:
  - Neither requesting: no grant; state unchanged.
  - Only N requesting: grant N.
  - Both requesting, burst_cnt < MAX_BURST: grant last.
  - Both requesting, burst_cnt >= MAX_BURST: grant the other requester.
  - Both requesting, burst_cnt == 0 (after reset): grant ~last.
- On a grant to N:
  - If N == last, burst_cnt <= burst_cnt + 1, saturating at MAX_BURST.
  - Otherwise last <= N and burst_cnt <= 1.
- Memory drive (combinational):
  - With a grant: mem_address = granted addr; mem_writedata = granted wdata; mem_memwrite = granted we; mem_memread = ~granted we.
  - With no grant: both strobes 0; address and writedata 0.
- Read return:
  - On a granted read, mem_readdata is captured at the clock edge.
  - In the next cycle, rvalidN = 1 for exactly one cycle, with rdataN = captured data.
  - The other requester's rvalid stays 0.
  - rdataN holds its last value when rvalidN = 0.
- Latency:
  - Read: gnt in cycle T, rvalid/rdata in cycle T+1.
  - Write: completes at the edge ending cycle T; no response beat.
- Back-to-back: a new grant is allowed every cycle. A read in T+1 returns in T+2, so pipelined reads stream one per cycle.
- Write-then-read to the same address in consecutive cycles returns the new data.
- Reset:
  - gnt0/gnt1 = 0, rvalid0/rvalid1 = 0, rdata0/rdata1 = 0, mem_memread/mem_memwrite = 0, last = 1, burst_cnt = 0.
  - Reset asserted the cycle after a read grant suppresses that rvalid; the result is discarded.
  - While reset = 1, no grants are issued regardless of req.

Test Plan:
- Single read: preload mem[5]=32'hDEADBEEF; req0=1, we0=0, addr0=5 -> gnt0=1 same cycle, mem_memread=1, mem_address=5; next cycle rvalid0=1, rdata0=32'hDEADBEEF, rvalid1=0.
- Tie after reset: req0 and req1 asserted together (reads) -> gnt0 first; next cycle (both still requesting, burst_cnt=1<4) gnt0 again.
- Burst limit, MAX_BURST=4: req0 continuous, req1 continuous -> grant sequence 0,0,0,0,1,1,1,1,0,… and never both gnt high.
- Strict alternation, MAX_BURST=1: both continuous -> 0,1,0,1; only req1 continuous -> gnt1 every cycle.
- Write/read turnaround: req1 writes 32'h12345678 to addr 1023 in cycle T, reads addr 1023 in T+1 -> mem_memwrite=1 in T only; rvalid1 in T+2 with rdata1=32'h12345678.
- Reset mid-operation: read granted in T, reset=1 in T+1 -> rvalid0=0 in T+1 and T+2, gnt0=0 while reset is high; after release, tie resolves to requester 0.
